// File: rtl/joint_pkg.sv
// Shared types and helpers for the joint command-stage plugins.
package joint_pkg;

  localparam int FREQ_W = 32;

  typedef logic signed [FREQ_W-1:0] freq_t;

  typedef enum logic [1:0] {
    DISABLED,
    TRACK,
    TRIP
  } ramp_state_t;

  // Clamp a signed frequency to the symmetric window [-max, +max].
  // max must be positive, so its negation always fits in the type.
  function automatic freq_t clamp_freq(input freq_t value, input freq_t max);
    freq_t neg_max;
    neg_max = -max;
    if (value > max) begin
      return max;
    end else if (value < neg_max) begin
      return neg_max;
    end
    return value;
  endfunction

endpackage

// File: rtl/joint_tick_prescaler.sv
// Free-running update-tick prescaler shared by the joint plugins.
// Counts 0..UPDATE_DIV-1 and pulses tick on the last count. The count is
// held at zero while enable is low, so the first tick after enabling
// arrives a full UPDATE_DIV-1 cycles later.
module joint_tick_prescaler #(
  parameter int UPDATE_DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int                CNT_W    = $clog2(UPDATE_DIV);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(UPDATE_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick = (cnt_q == CNT_LAST);

  // Count register: wraps on the last count, parked at zero while disabled.
  // NOTE: clocked state is always assigned with <= so every register samples
  // the pre-edge values of the others, whatever order the statements are in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!enable || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/joint_freqramp.sv
// Acceleration-limited velocity command stage feeding joint_pwmdir.
// The host target is clamped and latched; the command slews toward it by at
// most ACCEL_STEP per update tick. A host watchdog forces the effective
// target to zero when targetValid stops arriving.
module joint_freqramp
  import joint_pkg::*;
#(
  parameter int UPDATE_DIV = 1000,
  parameter int ACCEL_STEP = 16,
  parameter int FREQ_MAX   = 2000000,
  parameter int WDT_CYCLES = 4800000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [FREQ_W-1:0] jointFreqTarget,
  input  logic              targetValid,
  output logic [FREQ_W-1:0] jointFreqCmd,
  output logic              atTarget,
  output logic              wdtTripped
);

  localparam freq_t                  FMAX     = freq_t'(FREQ_MAX);
  localparam freq_t                  STEP     = freq_t'(ACCEL_STEP);
  localparam logic signed [FREQ_W:0] STEP_X   = (FREQ_W + 1)'(ACCEL_STEP);
  localparam int                     WDT_W    = $clog2(WDT_CYCLES + 1);
  localparam logic [WDT_W-1:0]       WDT_LAST = WDT_W'(WDT_CYCLES - 1);

  ramp_state_t             state_q, state_d;
  freq_t                   tgt_q, tgt_d;
  freq_t                   cmd_q, cmd_d;
  freq_t                   efft_q, efft_d;
  freq_t                   ramp_cmd;
  logic signed [FREQ_W:0]  diff;
  logic [WDT_W-1:0]        wdt_q, wdt_d;
  logic                    trip_q, trip_d;
  logic                    at_q, at_d;
  logic                    tick;

  joint_tick_prescaler #(
    .UPDATE_DIV (UPDATE_DIV)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .tick   (tick)
  );

  // The trip forces the target to zero without disturbing the latched value,
  // so a fresh strobe is needed to resume motion.
  assign efft_q = trip_q ? '0 : tgt_q;
  assign efft_d = trip_d ? '0 : tgt_d;

  // Widened by one bit: +FREQ_MAX minus -FREQ_MAX cannot overflow.
  assign diff = $signed({efft_q[FREQ_W-1], efft_q}) - $signed({cmd_q[FREQ_W-1], cmd_q});

  // One ramp step: a full step when far away, otherwise land exactly on target.
  always_comb begin
    ramp_cmd = efft_q;
    if (diff > STEP_X) begin
      ramp_cmd = cmd_q + STEP;
    end else if (diff < -STEP_X) begin
      ramp_cmd = cmd_q - STEP;
    end
  end

  // Target latch and host watchdog; a strobe on the expiry cycle wins.
  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    tgt_d  = tgt_q;
    wdt_d  = wdt_q;
    trip_d = trip_q;
    if (targetValid) begin
      tgt_d  = clamp_freq(freq_t'(jointFreqTarget), FMAX);
      wdt_d  = '0;
      trip_d = 1'b0;
    end else if (wdt_q == WDT_LAST) begin
      trip_d = 1'b1;
    end else begin
      wdt_d = wdt_q + WDT_W'(1);
    end
  end

  // Ramp FSM next state and command; enable low overrides everything.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    unique case (state_q)
      DISABLED: begin
        cmd_d = '0;
        if (enable) state_d = TRACK;
      end
      TRACK: begin
        if (tick) cmd_d = ramp_cmd;
        if (trip_d) state_d = TRIP;
      end
      TRIP: begin
        if (tick) cmd_d = ramp_cmd;
        if (targetValid) state_d = TRACK;
      end
      default: begin
        state_d = DISABLED;
        cmd_d   = '0;
      end
    endcase
    if (!enable) begin
      state_d = DISABLED;
      cmd_d   = '0;
    end
    at_d = (cmd_d == efft_d);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DISABLED;
      tgt_q   <= '0;
      cmd_q   <= '0;
      wdt_q   <= '0;
      trip_q  <= 1'b0;
      at_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      cmd_q   <= cmd_d;
      wdt_q   <= wdt_d;
      trip_q  <= trip_d;
      at_q    <= at_d;
    end
  end

  assign jointFreqCmd = cmd_q;
  assign atTarget     = at_q;
  assign wdtTripped   = trip_q;

endmodule

// File: tb/tb_joint_freqramp.sv
// Self-checking bench for joint_freqramp: directed plan steps followed by a
// randomized phase, all compared every cycle against a behavioural model.
module tb_joint_freqramp;

  localparam int DIV  = 4;
  localparam int STEP = 16;
  localparam int FMAX = 1000;
  localparam int WDT  = 200;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [31:0] jointFreqTarget;
  logic        targetValid;
  logic [31:0] jointFreqCmd;
  logic        atTarget;
  logic        wdtTripped;

  int n_asserts = 0;
  int n_fail    = 0;

  // Behavioural model state.
  longint m_tgt, m_cmd;
  int     m_phase, m_idle;
  bit     m_trip, m_at;
  logic [31:0] cur_target;

  joint_freqramp #(
    .UPDATE_DIV (DIV),
    .ACCEL_STEP (STEP),
    .FREQ_MAX   (FMAX),
    .WDT_CYCLES (WDT)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .enable          (enable),
    .jointFreqTarget (jointFreqTarget),
    .targetValid     (targetValid),
    .jointFreqCmd    (jointFreqCmd),
    .atTarget        (atTarget),
    .wdtTripped      (wdtTripped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint clamp_ref(input longint v);
    if (v > FMAX) return FMAX;
    if (v < -FMAX) return -FMAX;
    return v;
  endfunction

  function automatic longint step_toward(input longint d);
    if (d > STEP) return STEP;
    if (d < -STEP) return -STEP;
    return d;
  endfunction

  task automatic model_reset();
    m_tgt = 0; m_cmd = 0; m_phase = 0; m_idle = 0; m_trip = 0; m_at = 0;
  endtask

  // One clock edge of the reference behaviour, using the inputs held over it.
  task automatic model_step();
    longint efft;
    efft = m_trip ? 0 : m_tgt;
    if (!enable) m_cmd = 0;
    else if (m_phase == DIV - 1) m_cmd = m_cmd + step_toward(efft - m_cmd);
    m_phase = enable ? (m_phase + 1) % DIV : 0;
    if (targetValid) begin
      m_tgt  = clamp_ref(longint'($signed(jointFreqTarget)));
      m_idle = 0;
      m_trip = 0;
    end else begin
      if (m_idle < WDT) m_idle++;
      if (m_idle >= WDT) m_trip = 1;
    end
    m_at = (m_cmd == (m_trip ? 0 : m_tgt));
  endtask

  task automatic check_outputs();
    check("cmd", longint'($signed(jointFreqCmd)), m_cmd);
    check("atTarget", {63'd0, atTarget}, {63'd0, m_at});
    check("wdtTripped", {63'd0, wdtTripped}, {63'd0, m_trip});
  endtask

  // One full clock: model follows the edge, outputs checked on the falling edge.
  task automatic cyc();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    check_outputs();
    targetValid = 1'b0;
  endtask

  task automatic strobe(input logic [31:0] v);
    cur_target      = v;
    jointFreqTarget = v;
    targetValid     = 1'b1;
    cyc();
  endtask

  // n cycles; with keepalive the current target is re-sent every 50 cycles.
  task automatic run(input int n, input bit keepalive);
    for (int i = 0; i < n; i++) begin
      if (keepalive && (i % 50 == 49)) begin
        jointFreqTarget = cur_target;
        targetValid     = 1'b1;
      end
      cyc();
    end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; targetValid = 1'b0;
    jointFreqTarget = '0; cur_target = '0;
    model_reset();
    #1;
    check("reset_cmd", longint'($signed(jointFreqCmd)), 0);
    check("reset_at", {63'd0, atTarget}, 64'd0);
    check("reset_wdt", {63'd0, wdtTripped}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(3, 0);

    // Up-ramp to 100.
    strobe(32'd100);
    run(40, 0);
    check("up_final", longint'($signed(jointFreqCmd)), 100);
    check("up_at", {63'd0, atTarget}, 64'd1);

    // Reversal through zero to -50.
    strobe(-32'sd50);
    run(60, 0);
    check("rev_final", longint'($signed(jointFreqCmd)), -50);

    // Clamp to +1000, then the most negative target to -1000.
    strobe(32'd5000);
    run(300, 1);
    check("clamp_pos", longint'($signed(jointFreqCmd)), 1000);
    strobe(32'h8000_0000);
    run(520, 1);
    check("clamp_neg", longint'($signed(jointFreqCmd)), -1000);

    // Watchdog: hold at +1000, let the host go quiet.
    strobe(32'd5000);
    run(520, 1);
    check("wdt_hold", longint'($signed(jointFreqCmd)), 1000);
    run(200, 0);
    check("wdt_trip", {63'd0, wdtTripped}, 64'd1);
    run(270, 0);
    check("wdt_zero", longint'($signed(jointFreqCmd)), 0);
    strobe(32'd300);
    check("wdt_clear", {63'd0, wdtTripped}, 64'd0);
    run(100, 0);
    check("wdt_resume", longint'($signed(jointFreqCmd)), 300);

    // Strobe on the exact expiry cycle, then one cycle past it.
    strobe(32'd300);
    run(199, 0);
    check("wdt_edge_pre", {63'd0, wdtTripped}, 64'd0);
    strobe(32'd300);
    check("wdt_coincide", {63'd0, wdtTripped}, 64'd0);
    run(199, 0);
    check("wdt_199", {63'd0, wdtTripped}, 64'd0);
    run(1, 0);
    check("wdt_200", {63'd0, wdtTripped}, 64'd1);
    strobe(32'd300);
    run(4, 0);

    // Enable: target latched while disabled, drop at 48, restart from 0.
    enable = 1'b0;
    cyc();
    check("dis_zero", longint'($signed(jointFreqCmd)), 0);
    strobe(32'd200);
    enable = 1'b1;
    for (int i = 0; i < 100 && m_cmd != 48; i++) cyc();
    check("en_at48", longint'($signed(jointFreqCmd)), 48);
    enable = 1'b0;
    cyc();
    check("dis_cmd", longint'($signed(jointFreqCmd)), 0);
    run(5, 0);
    enable = 1'b1;
    run(3, 0);
    check("reen_hold", longint'($signed(jointFreqCmd)), 0);
    run(1, 0);
    check("reen_first", longint'($signed(jointFreqCmd)), 16);
    run(60, 0);
    check("reen_final", longint'($signed(jointFreqCmd)), 200);

    // Asynchronous reset while tripped and mid-ramp.
    strobe(32'd1000);
    run(120, 1);
    run(200, 0);
    check("pre_rst_trip", {63'd0, wdtTripped}, 64'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_cmd", longint'($signed(jointFreqCmd)), 0);
    check("rst_wdt", {63'd0, wdtTripped}, 64'd0);
    check("rst_at", {63'd0, atTarget}, 64'd0);
    #1;
    rst_n = 1'b1;
    run(10, 0);

    // Randomized traffic in blocks with varying strobe density.
    for (int b = 0; b < 6; b++) begin
      int rate;
      rate = $urandom_range(0, 8);
      for (int i = 0; i < 300; i++) begin
        int r;
        r = $urandom_range(0, 99);
        if (r < 2) enable = ~enable;
        if (r >= 10 && r < 10 + rate) begin
          if ($urandom_range(0, 3) == 0) jointFreqTarget = $urandom();
          else jointFreqTarget = 32'($signed($urandom_range(0, 2400)) - 1200);
          targetValid = 1'b1;
        end
        cyc();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
